// File: rtl/ntr_reply_engine.sv
// NTR cartridge reply engine: after a command is captured, serves one reply byte
// per NTR clock until chip-select releases. Replies are fixed words or FIFO-fed records.
module ntr_reply_engine #(
  parameter int LIMIT = 8192,
  parameter int CNT_W = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ntr_clk,
  input  logic        ntr_cs1,
  input  logic [63:0] command,
  input  logic        cmd_ready,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  data_out,
  output logic        drive_en,
  output logic        led,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  state_t           state, state_nxt;
  logic             ntr_q, ntr_prev, rdy_prev;
  logic [7:0]       op;
  logic [CNT_W-1:0] n;
  logic             e;

  logic             fall, rise, leave;
  logic             upd, pop, e_nxt;
  logic [7:0]       cur_op, byte_nxt;
  logic [CNT_W-1:0] idx;
  logic             unused_cmd;

  assign unused_cmd = ^{command[63:57], command[55:8]};

  // ntr_clk gets a capture stage before edge compare, so bytes land 2 clk after the fall
  assign fall  = ntr_prev & ~ntr_q;
  assign rise  = ~rdy_prev & cmd_ready;
  assign leave = ntr_cs1 | ~cmd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise && !ntr_cs1) state_nxt = LOAD;
      LOAD:    state_nxt = SERVE;
      SERVE:   if (leave) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte generator: picks the byte index for this cycle's update (if any) and builds it
  always_comb begin
    upd      = 1'b0;
    cur_op   = op;
    idx      = n;
    byte_nxt = 8'h00;
    pop      = 1'b0;
    e_nxt    = e;
    case (state)
      LOAD: begin
        upd    = 1'b1;
        cur_op = command[7:0];
        idx    = '0;
      end
      SERVE: begin
        // exit outranks a coincident falling edge
        if (!leave && fall) begin
          upd = 1'b1;
          idx = (n >= LIM) ? LIM : n + CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (idx >= LIM) begin
      byte_nxt = 8'hFF;
    end else begin
      case (cur_op)
        8'hFF: byte_nxt = (idx[1:0] == 2'd0) ? 8'h01 : 8'h00;
        8'h90: begin
          case (idx[1:0])
            2'd0:    byte_nxt = 8'hE0;
            2'd1:    byte_nxt = 8'h01;
            2'd2:    byte_nxt = 8'h7F;
            default: byte_nxt = 8'h80;
          endcase
        end
        8'h9F: byte_nxt = 8'hFF;
        8'h22: begin
          case (idx[1:0])
            2'd0: begin
              e_nxt = fifo_empty;
              if (!fifo_empty) begin
                byte_nxt = fifo_data;
                pop      = upd;
              end
            end
            2'd3:    byte_nxt = {7'b0, e};
            default: byte_nxt = 8'h00;
          endcase
        end
        default: byte_nxt = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ntr_q    <= 1'b1;
      ntr_prev <= 1'b1;
      rdy_prev <= 1'b1;
      data_out <= 8'hFF;
      led      <= 1'b0;
      n        <= '0;
      op       <= 8'h00;
      e        <= 1'b0;
    end else begin
      state    <= state_nxt;
      ntr_q    <= ntr_clk;
      ntr_prev <= ntr_q;
      rdy_prev <= cmd_ready;
      if (upd) begin
        data_out <= byte_nxt;
        n        <= idx;
        e        <= e_nxt;
      end
      if (state == LOAD) begin
        op <= command[7:0];
        if (command[7:0] == 8'hFF) led <= command[56];
      end
    end
  end

  // rst_n gating keeps a reset mid-record from popping on the reset edge
  assign fifo_rd_en = pop & rst_n;
  assign drive_en   = ((state == LOAD) || (state == SERVE && cmd_ready)) && !ntr_cs1;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ntr_reply_engine.sv
// Scoreboard bench for ntr_reply_engine: a default-LIMIT instance and a LIMIT=8 instance
// share stimulus; a queue-based FIFO feeds whichever instance is selected.
module tb_ntr_reply_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ntr_clk = 1'b1;
  logic        ntr_cs1 = 1'b1;
  logic [63:0] command = '0;
  logic        cmd_ready = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty = 1'b1;

  logic       rd0, de0, led0, busy0;
  logic [7:0] d0;
  logic       rd8, de8, led8, busy8;
  logic [7:0] d8;

  logic [7:0] fq[$];     // FIFO contents seen by the DUT
  logic [7:0] mq[$];     // model copy consumed when predicting bytes
  logic [7:0] exp_q[$];  // expected reply bytes
  int pops = 0, bad_pops = 0, n_chk = 0, n_pass = 0;
  logic sel8 = 1'b0;

  always #5 clk = ~clk;

  ntr_reply_engine dut (
    .clk(clk), .rst_n(rst_n), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1),
    .command(command), .cmd_ready(cmd_ready), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_rd_en(rd0), .data_out(d0),
    .drive_en(de0), .led(led0), .busy(busy0)
  );

  ntr_reply_engine #(.LIMIT(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1),
    .command(command), .cmd_ready(cmd_ready), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_rd_en(rd8), .data_out(d8),
    .drive_en(de8), .led(led8), .busy(busy8)
  );

  // FWFT FIFO: head refreshed on negedge, pop strobe sampled just before posedge
  always begin
    @(negedge clk);
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    #4;
    if (sel8 ? rd8 : rd0) begin
      pops++;
      if (fq.size() == 0) bad_pops++;
      else void'(fq.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, checks so far %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic load_fifo(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int cnt);
    logic [7:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < cnt; i++) begin
      fq.push_back(bs[i]);
      mq.push_back(bs[i]);
    end
    @(negedge clk);
  endtask

  // Reference model: pushes the nb expected bytes, returns the pops it implies
  task automatic push_exp(input logic [7:0] op, input int nb, input int lim, output int npop);
    logic       e;
    logic [7:0] b;
    logic [31:0] w;
    e = 1'b0;
    npop = 0;
    for (int i = 0; i < nb; i++) begin
      b = 8'h00;
      if (i >= lim) b = 8'hFF;
      else begin
        case (op)
          8'hFF: w = 32'h0000_0001;
          8'h90: w = 32'h807F_01E0;
          8'h9F: w = 32'hFFFF_FFFF;
          default: w = 32'h0;
        endcase
        b = w[8*(i%4) +: 8];
        if (op == 8'h22) begin
          case (i % 4)
            0: if (mq.size() != 0) begin b = mq.pop_front(); e = 1'b0; npop++; end
               else begin b = 8'h00; e = 1'b1; end
            3: b = {7'b0, e};
            default: b = 8'h00;
          endcase
        end
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic start_cmd(input logic [63:0] c);
    command = c; cmd_ready = 1'b1; ntr_cs1 = 1'b0;
    @(negedge clk);
    n_chk++;
    if ((sel8 ? busy8 : busy0) !== 1'b1) $display("FAIL load_busy: busy=%b want 1", sel8 ? busy8 : busy0);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic end_cmd();
    ntr_cs1 = 1'b1;
    #1;
    n_chk++;
    if ((sel8 ? de8 : de0) !== 1'b0) $display("FAIL exit_drive_en: drive_en=%b want 0", sel8 ? de8 : de0);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ((sel8 ? busy8 : busy0) !== 1'b0) $display("FAIL exit_busy: busy=%b want 0", sel8 ? busy8 : busy0);
    else n_pass++;
    cmd_ready = 1'b0;
    @(negedge clk);
  endtask

  // Host side: samples a byte, then clocks ntr_clk low/high to advance
  task automatic read_bytes(input int nb);
    logic [7:0] got, exp;
    for (int k = 0; k < nb; k++) begin
      if (k > 0) begin
        ntr_clk = 1'b0; repeat (4) @(negedge clk);
        ntr_clk = 1'b1; repeat (4) @(negedge clk);
      end
      got = sel8 ? d8 : d0;
      n_chk++;
      if (exp_q.size() == 0) $display("FAIL byte%0d: got %02h, nothing expected", k, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL byte%0d: got %02h want %02h", k, got, exp);
        else n_pass++;
      end
      n_chk++;
      if ((sel8 ? de8 : de0) !== 1'b1) $display("FAIL drive_en byte%0d: got %b want 1", k, sel8 ? de8 : de0);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      command = {$urandom, $urandom};
      cmd_ready = 1'($urandom_range(0, 1));
      ntr_cs1   = 1'($urandom_range(0, 1));
      ntr_clk   = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_chk++;
      if ((rd0 | rd8) !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd0 | rd8);
      else n_pass++;
    end
    n_chk++; if (d0 !== 8'hFF) $display("FAIL reset_data: got %02h want ff", d0); else n_pass++;
    n_chk++; if (de0 !== 1'b0) $display("FAIL reset_drive_en: got %b want 0", de0); else n_pass++;
    n_chk++; if (led0 !== 1'b0) $display("FAIL reset_led: got %b want 0", led0); else n_pass++;
    n_chk++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else n_pass++;
    cmd_ready = 1'b0; ntr_cs1 = 1'b1; ntr_clk = 1'b1; command = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word_90();
    int np;
    push_exp(8'h90, 8, 8192, np);
    start_cmd(64'h90);
    read_bytes(8);
    end_cmd();
  endtask

  task automatic test_word_other();
    int np;
    push_exp(8'h3C, 4, 8192, np);
    start_cmd(64'h3C);
    read_bytes(4);
    end_cmd();
  endtask

  task automatic test_record_22();
    int np, p0;
    load_fifo(8'h41, 8'h42, 8'h00, 8'h00, 2);
    push_exp(8'h22, 12, 8192, np);
    p0 = pops;
    start_cmd(64'h22);
    read_bytes(12);
    end_cmd();
    n_chk++; if (pops - p0 !== np) $display("FAIL rec_pops: got %0d want %0d", pops - p0, np); else n_pass++;
    n_chk++; if (bad_pops !== 0) $display("FAIL rec_empty_pop: got %0d want 0", bad_pops); else n_pass++;
  endtask

  task automatic test_led();
    int np;
    push_exp(8'hFF, 4, 8192, np);
    start_cmd({7'b0, 1'b1, 48'h0, 8'hFF});
    n_chk++; if (led0 !== 1'b1) $display("FAIL led_set: got %b want 1", led0); else n_pass++;
    read_bytes(4);
    end_cmd();
    push_exp(8'h9F, 4, 8192, np);
    start_cmd({7'b0, 1'b1, 48'h0, 8'h9F} ^ 64'h0100_0000_0000_0000);
    read_bytes(4);
    end_cmd();
    n_chk++; if (led0 !== 1'b1) $display("FAIL led_hold: got %b want 1", led0); else n_pass++;
    push_exp(8'hFF, 4, 8192, np);
    start_cmd(64'hFF);
    n_chk++; if (led0 !== 1'b0) $display("FAIL led_clear: got %b want 0", led0); else n_pass++;
    read_bytes(4);
    end_cmd();
  endtask

  task automatic test_limit();
    int np, p0;
    sel8 = 1'b1;
    load_fifo(8'hA1, 8'hA2, 8'hA3, 8'hA4, 4);
    push_exp(8'h22, 12, 8, np);
    p0 = pops;
    start_cmd(64'h22);
    read_bytes(12);
    end_cmd();
    n_chk++; if (pops - p0 !== 2) $display("FAIL limit_pops: got %0d want 2", pops - p0); else n_pass++;
    n_chk++; if (np !== 2) $display("FAIL limit_model_pops: got %0d want 2", np); else n_pass++;
    fq.delete(); mq.delete();
    sel8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_serve();
    int np, p0;
    load_fifo(8'h11, 8'h22, 8'h33, 8'h00, 3);
    push_exp(8'h22, 5, 8192, np);
    start_cmd(64'h22);
    read_bytes(5);
    p0 = pops;
    rst_n = 1'b0;
    ntr_clk = 1'b0; repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ntr_clk = 1'b1; repeat (4) @(negedge clk);
    n_chk++; if (pops !== p0) $display("FAIL rst_mid_pops: got %0d want %0d", pops, p0); else n_pass++;
    n_chk++; if (busy0 !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0 (needs fresh cmd_ready rise)", busy0); else n_pass++;
    n_chk++; if (d0 !== 8'hFF) $display("FAIL rst_mid_data: got %02h want ff", d0); else n_pass++;
    n_chk++; if (fq.size() !== 1) $display("FAIL rst_mid_fifo: got %0d want 1", fq.size()); else n_pass++;
    cmd_ready = 1'b0; ntr_cs1 = 1'b1;
    @(negedge clk);
    push_exp(8'h22, 4, 8192, np);
    p0 = pops;
    start_cmd(64'h22);
    read_bytes(4);
    end_cmd();
    n_chk++; if (pops - p0 !== 1) $display("FAIL restart_pops: got %0d want 1", pops - p0); else n_pass++;
    n_chk++; if (bad_pops !== 0) $display("FAIL empty_pops: got %0d want 0", bad_pops); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_word_90();
    test_word_other();
    test_record_22();
    test_led();
    test_limit();
    test_reset_mid_serve();
    n_chk++; if (exp_q.size() !== 0) $display("FAIL leftover_expected: got %0d want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
